explode_timer: RTL

- Frame-rate timer serving the tank explosion animation FSM.
- Receives the level request `timer_start` from the animation FSM and returns `timer_flag`, a one-cycle pulse every TICK_FRAMES frames, used to advance one explosion frame.
- Counts the pulses, stops after NUM_TICKS, and reports completion.
- Sits beside the explosion FSM, clocked by the frame clock (one cycle per video frame).

---
 rtl/explode_pkg.sv | 14 +
 rtl/explode_timer_frame_divider.sv | 28 ++
 rtl/explode_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/explode_pkg.sv
// Shared types and default timing for the tank explosion animation.
// The defaults also size the explosion FSM and the sprite ROM frame count.
package explode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int EXPLODE_TICK_FRAMES = 6;
    localparam int EXPLODE_NUM_TICKS   = 11;

endpackage

// File: rtl/explode_timer_frame_divider.sv
// Modulo-TICK_FRAMES frame counter with enable and synchronous clear.
// at_terminal marks the frame on which the next enabled edge wraps the count.
module frame_divider #(
    parameter int TICK_FRAMES = 6
) (
    input  logic frame_clk,
    input  logic Reset_n,
    input  logic enable,
    input  logic clear,
    output logic at_terminal
);

    localparam int CW = $clog2(TICK_FRAMES);
    localparam logic [CW-1:0] LAST_FRAME = CW'(TICK_FRAMES - 1);

    logic [CW-1:0] frame_cnt;

    always_ff @(posedge frame_clk) begin
        if (!Reset_n || clear) begin
            frame_cnt <= '0;
        end else if (enable) begin
            frame_cnt <= at_terminal ? '0 : frame_cnt + CW'(1);
        end
    end

    assign at_terminal = (frame_cnt == LAST_FRAME);

endmodule

// File: rtl/explode_timer.sv
// Frame-rate timer for the explosion animation: pulses timer_flag every
// TICK_FRAMES frames while running, and stops after NUM_TICKS pulses.
module explode_timer
    import explode_pkg::*;
#(
    parameter int TICK_FRAMES = EXPLODE_TICK_FRAMES,
    parameter int NUM_TICKS   = EXPLODE_NUM_TICKS
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       timer_start,
    input  logic       game_pause,
    output logic       timer_flag,
    output logic [3:0] tick_count,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_TICK = 4'(NUM_TICKS);

    timer_state_t state, state_next;
    logic [3:0]   tick_q, tick_next;
    logic         flag_q, flag_next;
    logic         div_en, div_clr, at_terminal;
    logic [3:0]   tick_inc;

    // An abort edge must neither advance nor pulse, so the divider only runs
    // while the request is still present.
    assign div_en  = (state == RUN) && timer_start && !game_pause;
    assign div_clr = (state != RUN) || !timer_start;

    frame_divider #(
        .TICK_FRAMES(TICK_FRAMES)
    ) u_divider (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .enable     (div_en),
        .clear      (div_clr),
        .at_terminal(at_terminal)
    );

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state  <= IDLE;
            tick_q <= '0;
            flag_q <= 1'b0;
        end else begin
            state  <= state_next;
            tick_q <= tick_next;
            flag_q <= flag_next;
        end
    end

    assign tick_inc = tick_q + 4'd1;

    always_comb begin
        state_next = state;
        tick_next  = tick_q;
        flag_next  = 1'b0;
        case (state)
            IDLE: begin
                tick_next = '0;
                if (timer_start && !game_pause) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!timer_start) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end else if (!game_pause && at_terminal) begin
                    flag_next = 1'b1;
                    tick_next = tick_inc;
                    if (tick_inc == LAST_TICK) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!timer_start) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    assign timer_flag = flag_q;
    assign tick_count = tick_q;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

endmodule
